// File: rtl/damage_encoder.sv
// rtl/damage_encoder.sv - per-tick damage accumulator streaming (select, total) pairs to the decoder
// Optional build macro: DAMAGE_EMIT_SKIP_EN (emit only targets hit with nonzero damage).
module damage_encoder #(
    parameter int NUM_ATTACKERS = 16,
    parameter int ACC_WIDTH     = 12
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         tick,
    input  logic [NUM_ATTACKERS-1:0]     attackValid,
    input  logic [5*NUM_ATTACKERS-1:0]   attackTargetBus,
    input  logic [8*NUM_ATTACKERS-1:0]   attackDamageBus,
    output logic [4:0]                   damageSelect,
    output logic [ACC_WIDTH-1:0]         totalDamage,
    output logic                         damageValid,
    output logic                         busy,
    output logic                         done
);

    localparam int          NUM_TARGETS = 17;
    localparam logic [4:0]  TOWER       = 5'd16;
    localparam logic [4:0]  LAST_SLOT   = 5'(NUM_ATTACKERS - 1);
    localparam logic [4:0]  IDLE_SELECT = 5'b11111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_SCAN,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                        state_q, state_d;
    logic [4:0]                    idx_q, idx_d;
    logic [NUM_ATTACKERS-1:0]      valid_sh_q, valid_sh_d;
    logic [5*NUM_ATTACKERS-1:0]    target_sh_q, target_sh_d;
    logic [8*NUM_ATTACKERS-1:0]    damage_sh_q, damage_sh_d;
    logic [ACC_WIDTH-1:0]          acc_q [NUM_TARGETS];
    logic [ACC_WIDTH-1:0]          acc_d [NUM_TARGETS];

    logic [4:0]                    select_q, select_d;
    logic [ACC_WIDTH-1:0]          total_q, total_d;
    logic                          dvalid_q, dvalid_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;

`ifdef DAMAGE_EMIT_SKIP_EN
    logic [NUM_TARGETS-1:0]        mask_q, mask_d;

    function automatic logic [4:0] lowest_idx(input logic [NUM_TARGETS-1:0] m);
        lowest_idx = 5'd0;
        for (int k = NUM_TARGETS - 1; k >= 0; k--) begin
            if (m[k]) lowest_idx = 5'(k);
        end
    endfunction
`endif

    // Current scan slot, pulled from the shadow copies
    logic                          slot_valid;
    logic [4:0]                    slot_target;
    logic [7:0]                    slot_damage;
    logic [4:0]                    slot_acc_idx;
    logic [ACC_WIDTH-1:0]          slot_acc;
    logic [ACC_WIDTH:0]            slot_sum;
    logic [ACC_WIDTH-1:0]          slot_sat;

    always_comb begin
        slot_valid  = 1'b0;
        slot_target = 5'd0;
        slot_damage = 8'd0;
        for (int i = 0; i < NUM_ATTACKERS; i++) begin
            if (idx_q == 5'(i)) begin
                slot_valid  = valid_sh_q[i];
                slot_target = target_sh_q[5*i +: 5];
                slot_damage = damage_sh_q[8*i +: 8];
            end
        end
        slot_acc_idx = slot_target[4] ? TOWER : slot_target;
        slot_acc     = '0;
        for (int k = 0; k < NUM_TARGETS; k++) begin
            if (slot_acc_idx == 5'(k)) slot_acc = acc_q[k];
        end
        slot_sum = {1'b0, slot_acc} + {{(ACC_WIDTH - 7){1'b0}}, slot_damage};
        slot_sat = slot_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : slot_sum[ACC_WIDTH-1:0];
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        valid_sh_d  = valid_sh_q;
        target_sh_d = target_sh_q;
        damage_sh_d = damage_sh_q;
        acc_d       = acc_q;
`ifdef DAMAGE_EMIT_SKIP_EN
        mask_d      = mask_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (tick) state_d = S_LATCH;
            end

            S_LATCH: begin
                valid_sh_d  = attackValid;
                target_sh_d = attackTargetBus;
                damage_sh_d = attackDamageBus;
                for (int k = 0; k < NUM_TARGETS; k++) acc_d[k] = '0;
`ifdef DAMAGE_EMIT_SKIP_EN
                mask_d = '0;
`endif
                idx_d   = 5'd0;
                state_d = S_SCAN;
            end

            S_SCAN: begin
                if (slot_valid) begin
                    for (int k = 0; k < NUM_TARGETS; k++) begin
                        if (slot_acc_idx == 5'(k)) begin
                            acc_d[k] = slot_sat;
`ifdef DAMAGE_EMIT_SKIP_EN
                            if (slot_damage != 8'd0) mask_d[k] = 1'b1;
`endif
                        end
                    end
                end
                if (idx_q == LAST_SLOT) begin
`ifdef DAMAGE_EMIT_SKIP_EN
                    // First emitted target is taken from the mask including this slot's hit
                    if (mask_d == '0) begin
                        idx_d   = 5'd0;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = lowest_idx(mask_d);
                        mask_d  = mask_d & (mask_d - 1'b1);
                        state_d = S_EMIT;
                    end
`else
                    idx_d   = 5'd0;
                    state_d = S_EMIT;
`endif
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end

            S_EMIT: begin
`ifdef DAMAGE_EMIT_SKIP_EN
                if (mask_q == '0) begin
                    idx_d   = 5'd0;
                    state_d = S_DONE;
                end else begin
                    idx_d  = lowest_idx(mask_q);
                    mask_d = mask_q & (mask_q - 1'b1);
                end
`else
                if (idx_q == TOWER) begin
                    idx_d   = 5'd0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
`endif
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output registers track the state being entered, so each pair lines up with its EMIT cycle
    always_comb begin
        select_d = IDLE_SELECT;
        total_d  = '0;
        dvalid_d = 1'b0;
        if (state_d == S_EMIT) begin
            select_d = idx_d;
            dvalid_d = 1'b1;
            for (int k = 0; k < NUM_TARGETS; k++) begin
                if (idx_d == 5'(k)) total_d = acc_d[k];
            end
        end
        busy_d = (state_d == S_LATCH) || (state_d == S_SCAN) || (state_d == S_EMIT);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            idx_q       <= 5'd0;
            valid_sh_q  <= '0;
            target_sh_q <= '0;
            damage_sh_q <= '0;
            for (int k = 0; k < NUM_TARGETS; k++) acc_q[k] <= '0;
`ifdef DAMAGE_EMIT_SKIP_EN
            mask_q      <= '0;
`endif
            select_q    <= IDLE_SELECT;
            total_q     <= '0;
            dvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            valid_sh_q  <= valid_sh_d;
            target_sh_q <= target_sh_d;
            damage_sh_q <= damage_sh_d;
            for (int k = 0; k < NUM_TARGETS; k++) acc_q[k] <= acc_d[k];
`ifdef DAMAGE_EMIT_SKIP_EN
            mask_q      <= mask_d;
`endif
            select_q    <= select_d;
            total_q     <= total_d;
            dvalid_q    <= dvalid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign damageSelect = select_q;
    assign totalDamage  = total_q;
    assign damageValid  = dvalid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: doc/damage_encoder.md
Name: damage_encoder

Overview:
- Source side of the per-target damage interface.
- Once per game tick, latches up to 16 attacker requests (valid, target index, 8-bit damage) and sums damage per target into 17 saturating accumulators (units 0-15, tower 16).
- Then streams one target per cycle as a (select, total) pair into the combinational damage decoder.
- Instantiated twice at game top: once for the friendly side, once for the enemy side.

Parameters:
- NUM_ATTACKERS, 16, number of attacker request slots scanned per tick (1..16).
- ACC_WIDTH, 12, accumulator and totalDamage width; must be ≥ 9.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle start pulse; sampled only in IDLE
- attackValid  in  NUM_ATTACKERS  per-slot request valid
- attackTargetBus  in  5*NUM_ATTACKERS  slot i target at [5i+4:5i]; 0-15 = unit, ≥16 = tower
- attackDamageBus  in  8*NUM_ATTACKERS  slot i damage at [8i+7:8i]
- damageSelect  out  5  target select to decoder
- totalDamage  out  ACC_WIDTH  summed damage for damageSelect
- damageValid  out  1  high on cycles presenting a real target
- busy  out  1  high in LATCH, SCAN, EMIT
- done  out  1  one-cycle pulse after the last emit

Behaviour:
- Reset is asynchronous. While asserted:
  - state = IDLE; all accumulators = 0; scan/emit index = 0.
  - damageSelect = 5'b11111, totalDamage = 0, damageValid = 0, busy = 0, done = 0.
- Idle output contract: whenever damageValid = 0, damageSelect = 5'b11111 and totalDamage = 0. The decoder then routes zero to the tower, so no damage is ever applied spuriously.
- States:
  - IDLE: on tick = 1 go to LATCH.
  - LATCH (1 cycle): register attackValid, attackTargetBus and attackDamageBus into shadow copies; clear all 17 accumulators. Inputs may change freely after this cycle.
  - SCAN (NUM_ATTACKERS cycles, slot i on cycle i):
    - If shadow valid[i] = 1: acc[t] <= sat(acc[t] + damage[i]), where t = target[i] if target[i] < 16, else t = 16.
    - Invalid slots cost one cycle and change nothing.
  - EMIT (17 cycles, target k = 0..16 in order): damageSelect = k, totalDamage = acc[k], damageValid = 1. A target with acc = 0 is still presented, with total 0.
  - DONE (1 cycle): done = 1, outputs at idle values, then go to IDLE.
- Saturation: sum computed ACC_WIDTH+1 bits wide; if it exceeds 2^ACC_WIDTH−1, clamp to all-ones. The accumulator never wraps.
- Outputs are registered: the pair for target k appears the cycle after EMIT index = k is loaded. There is no combinational path from any input to any output.
- Latency, tick to done, without the macro: 1 (LATCH) + NUM_ATTACKERS + 17 + 1 = 35 cycles at the default; busy is high for the first 34.
- tick while busy: ignored, no queuing.
- tick in the same cycle done is high: ignored. The state is DONE, not IDLE.
- Multiple slots on the same target: summed in slot order; the result is order-independent apart from saturation.
- Reset mid-SCAN or mid-EMIT: immediate abort. Accumulators clear, no further emits, done is not pulsed.

Optional Feature:
- Macro: DAMAGE_EMIT_SKIP_EN
- Defined:
  - During SCAN, a 17-bit hit mask is set for every target touched with nonzero damage.
  - EMIT presents only masked targets, in ascending index order, one per cycle. A priority encoder clears the lowest set bit each cycle.
  - EMIT length = popcount(mask); an empty mask goes straight from SCAN to DONE.
  - Latency = 1 + NUM_ATTACKERS + popcount + 1.
- Undefined: fixed 17-cycle EMIT as described above, with no mask logic.

Test Plan:
- Single hit: slot 3 valid, target 5, damage 40 -> one EMIT cycle with select 5, total 40, valid 1; the other 16 emits show total 0; done 35 cycles after tick.
- Stacking and tower: slots 0,1,2 on target 7 with 100, 100, 60; slot 4 on target 20 with 9 -> select 7 total 260; select 16 total 9.
- Saturation: 16 slots all on target 0 with damage 255, ACC_WIDTH = 9 -> select 0 total 511 (clamped); no wrap.
- Busy handling: tick again at cycle 10 of SCAN -> ignored, exactly one done pulse. Changing attack inputs after LATCH -> emitted totals unchanged.
- Reset at EMIT index 8 -> outputs immediately 5'b11111 / 0 / valid 0, no done; next tick runs cleanly and starts from zeroed accumulators.
- With DAMAGE_EMIT_SKIP_EN: hits on targets 2 and 16 only -> exactly 2 valid cycles (select 2 then 16), done 20 cycles after tick. No valid slots -> done 18 cycles after tick with zero valid cycles.
